// File: rtl/dma_pkg.sv
// Shared definitions for the DMA device-side bridge.
// Holds the bridge state encoding, the transfer direction constants and the
// default address/data widths used by the bridge, its interface and its FIFO.
package dma_pkg;

    // Direction as seen by the DMA controller.
    localparam logic RD_MEM = 1'b1;   // memory -> peripheral
    localparam logic WR_MEM = 1'b0;   // peripheral -> memory

    localparam int DEF_ADD_LEN  = 16;
    localparam int DEF_DATA_LEN = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WR_XFER,
        S_RD_XFER,
        S_DRAIN,
        S_DONE
    } bridge_state_t;

endpackage

// File: rtl/dma_dev_bridge_if.sv
// Bridge <-> DMA controller link.
//   rqst/rd_wr            : one-cycle request pulse and transfer direction
//   start_addr/num_words  : latched command fields
//   dev_ack/dev_in        : bridge word offer (write) or slot offer (read)
//   dma_ack/dev_out       : controller word handshake and read data
//   end_flag              : controller finished the transfer
// master = bridge side, slave = controller side.
interface dma_dev_bridge_if
    import dma_pkg::*;
#(
    parameter int ADD_LEN  = DEF_ADD_LEN,
    parameter int DATA_LEN = DEF_DATA_LEN
);
    logic                rqst;
    logic                rd_wr;
    logic [ADD_LEN:0]    start_addr;
    logic [ADD_LEN-1:0]  num_words;
    logic                dev_ack;
    logic [DATA_LEN-1:0] dev_in;
    logic                dma_ack;
    logic [DATA_LEN-1:0] dev_out;
    logic                end_flag;

    modport master (
        output rqst, rd_wr, start_addr, num_words, dev_ack, dev_in,
        input  dma_ack, dev_out, end_flag
    );

    modport slave (
        input  rqst, rd_wr, start_addr, num_words, dev_ack, dev_in,
        output dma_ack, dev_out, end_flag
    );
endinterface

// File: rtl/dma_bridge_fifo.sv
// Small synchronous FIFO buffering words between the DMA controller and the
// peripheral stream.
//   clk, reset      : clock, asynchronous active-low reset (clears storage)
//   clear           : synchronous flush of pointers and count
//   push/wdata      : write port; a push while full is accepted only with a pop
//   pop/rdata       : read port; rdata is the head word (show-ahead)
//   count/full/empty: occupancy
module dma_bridge_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != FULL_CNT) || do_pop);

    assign rdata = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/dma_dev_bridge.sv
// Device-side bridge in front of the DMA controller.
// Accepts one transfer command, issues the request, then streams words
// between the peripheral ports and the controller's dev_ack/dma_ack handshake
// through a small FIFO that covers the controller's one-cycle ack latency.
//   clk, reset               : clock, asynchronous active-low reset
//   cmd_*                    : command (valid/ready, direction, byte address, word count)
//   s_in_*                   : peripheral -> bridge stream (write direction)
//   m_out_*                  : bridge -> peripheral stream (read direction)
//   ctl                      : DMA controller link (master side)
//   busy, done, err, short   : status (done/err are one-cycle pulses)
module dma_dev_bridge
    import dma_pkg::*;
#(
    parameter int ADD_LEN   = DEF_ADD_LEN,
    parameter int DATA_LEN  = DEF_DATA_LEN,
    parameter int BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_rd_wr,
    input  logic [ADD_LEN:0]    cmd_addr,
    input  logic [ADD_LEN-1:0]  cmd_len,
    input  logic                s_in_valid,
    output logic                s_in_ready,
    input  logic [DATA_LEN-1:0] s_in_data,
    output logic                m_out_valid,
    input  logic                m_out_ready,
    output logic [DATA_LEN-1:0] m_out_data,
    dma_dev_bridge_if.master    ctl,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                short
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    bridge_state_t state, state_next;

    logic [ADD_LEN:0]    addr_q;
    logic [ADD_LEN-1:0]  len_q;
    logic                dir_q;
    logic [ADD_LEN-1:0]  in_cnt;
    logic [ADD_LEN-1:0]  xfer_cnt;
    logic                ovf_q;
    logic                short_q;
    logic                err_q;

    logic                rqst;
    logic                dev_ack;
    logic                clear;
    logic                push;
    logic                pop;
    logic                word_ok;
    logic                overflow;
    logic [DATA_LEN-1:0] push_data;
    logic [DATA_LEN-1:0] head;
    logic [CW-1:0]       buf_cnt;
    logic                buf_full;
    logic                buf_empty;

    dma_bridge_fifo #(
        .WIDTH (DATA_LEN),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .count (buf_cnt),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        rqst        = 1'b0;
        dev_ack     = 1'b0;
        s_in_ready  = 1'b0;
        m_out_valid = 1'b0;
        clear       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        word_ok     = 1'b0;
        overflow    = 1'b0;
        push_data   = s_in_data;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && !cmd_addr[0]) begin
                    clear      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                rqst       = 1'b1;
                state_next = (dir_q == WR_MEM) ? S_WR_XFER : S_RD_XFER;
            end
            S_WR_XFER: begin
                s_in_ready = !buf_full && (in_cnt < len_q);
                push       = s_in_valid && s_in_ready;
                // A word already claimed by this cycle's dma_ack cannot be offered again.
                dev_ack    = (int'(buf_cnt) - int'(ctl.dma_ack)) >= 1;
                pop        = ctl.dma_ack && !buf_empty;
                word_ok    = pop;
                overflow   = ctl.dma_ack && buf_empty;
                if (ctl.end_flag) state_next = S_DONE;
            end
            S_RD_XFER: begin
                m_out_valid = !buf_empty;
                pop         = m_out_valid && m_out_ready;
                push_data   = ctl.dev_out;
                overflow    = ctl.dma_ack && buf_full && !pop;
                push        = ctl.dma_ack && !overflow;
                word_ok     = push;
                // Offer a slot only if one is still free after this cycle's
                // arrival and departure, since the answering word lands next cycle.
                dev_ack     = (int'(buf_cnt) + int'(ctl.dma_ack) - int'(pop)) < BUF_DEPTH;
                if (ctl.end_flag) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                m_out_valid = !buf_empty;
                pop         = m_out_valid && m_out_ready;
                if (buf_empty) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            dir_q    <= 1'b0;
            in_cnt   <= '0;
            xfer_cnt <= '0;
            ovf_q    <= 1'b0;
            short_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= (state == S_IDLE) && cmd_valid && cmd_addr[0];
            if (clear) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                dir_q    <= cmd_rd_wr;
                in_cnt   <= '0;
                xfer_cnt <= '0;
                ovf_q    <= 1'b0;
                short_q  <= 1'b0;
            end else begin
                if ((state == S_WR_XFER) && push) in_cnt <= in_cnt + 1'b1;
                if (word_ok) xfer_cnt <= xfer_cnt + 1'b1;
                if (overflow) ovf_q <= 1'b1;
                if (state == S_DONE) short_q <= ovf_q || (xfer_cnt != len_q);
            end
        end
    end

    assign ctl.rqst       = rqst;
    assign ctl.rd_wr      = dir_q;
    assign ctl.start_addr = addr_q;
    assign ctl.num_words  = len_q;
    assign ctl.dev_ack    = dev_ack;
    assign ctl.dev_in     = head;
    assign m_out_data     = head;

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign err   = err_q;
    assign short = short_q;
endmodule

// File: tb/tb_dma_dev_bridge.sv
module tb_dma_dev_bridge;
    import dma_pkg::*;

    localparam int ADD_LEN   = 16;
    localparam int DATA_LEN  = 16;
    localparam int BUF_DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                cmd_valid, cmd_ready, cmd_rd_wr;
    logic [ADD_LEN:0]    cmd_addr;
    logic [ADD_LEN-1:0]  cmd_len;
    logic                s_in_valid, s_in_ready;
    logic [DATA_LEN-1:0] s_in_data;
    logic                m_out_valid, m_out_ready;
    logic [DATA_LEN-1:0] m_out_data;
    logic                busy, done, err, short;

    dma_dev_bridge_if #(.ADD_LEN(ADD_LEN), .DATA_LEN(DATA_LEN)) ctl ();

    dma_dev_bridge #(
        .ADD_LEN   (ADD_LEN),
        .DATA_LEN  (DATA_LEN),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rd_wr   (cmd_rd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .s_in_valid  (s_in_valid),
        .s_in_ready  (s_in_ready),
        .s_in_data   (s_in_data),
        .m_out_valid (m_out_valid),
        .m_out_ready (m_out_ready),
        .m_out_data  (m_out_data),
        .ctl         (ctl),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .short       (short)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: word queues in transfer order plus controller/peripheral behaviour.
    logic [DATA_LEN-1:0] wr_src[$];   // words the peripheral still has to send
    logic [DATA_LEN-1:0] wr_exp[$];   // words accepted from the peripheral, owed to the controller
    logic [DATA_LEN-1:0] rd_exp[$];   // words returned by the controller, owed to the peripheral
    int  ctl_budget, ctl_gap, ctl_idle;
    bit  ctl_active, ctl_end_with_last, ctl_stall;
    bit  sin_rand, mout_rand;
    int  mout_hold;
    int  rqst_cnt, done_cnt, acks, delivered, sin_rdy_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/rqst"},        ctl.rqst, 0);
        check({tag, "/dev_ack"},     ctl.dev_ack, 0);
        check({tag, "/s_in_ready"},  s_in_ready, 0);
        check({tag, "/m_out_valid"}, m_out_valid, 0);
        check({tag, "/busy"},        busy, 0);
        check({tag, "/done"},        done, 0);
        check({tag, "/err"},         err, 0);
        check({tag, "/short"},       short, 0);
        check({tag, "/cmd_ready"},   cmd_ready, 1);
        check({tag, "/start_addr"},  ctl.start_addr, 0);
        check({tag, "/num_words"},   ctl.num_words, 0);
        check({tag, "/rd_wr"},       ctl.rd_wr, 0);
        check({tag, "/dev_in"},      ctl.dev_in, 0);
        check({tag, "/m_out_data"},  m_out_data, 0);
    endtask

    // One clock: observe at the falling edge, then drive the next inputs just after the rising edge.
    task automatic cycle();
        logic                nxt_ack;
        logic                nxt_end;
        logic [DATA_LEN-1:0] nxt_dout;
        @(negedge clk);
        if (ctl.rqst) rqst_cnt++;
        if (done) done_cnt++;
        if (s_in_ready) sin_rdy_cnt++;
        check("m_out_valid", m_out_valid, rd_exp.size() != 0);
        if (ctl.dma_ack && !ctl.rd_wr) begin
            if (wr_exp.size() == 0) check("wr_word_avail", 0, 1);
            else check("dev_in", ctl.dev_in, wr_exp.pop_front());
        end
        if (s_in_valid && s_in_ready) begin
            wr_exp.push_back(s_in_data);
            void'(wr_src.pop_front());
        end
        if (m_out_valid && m_out_ready) begin
            if (rd_exp.size() == 0) check("rd_word_avail", 0, 1);
            else check("m_out_data", m_out_data, rd_exp.pop_front());
            delivered++;
        end
        if (ctl.dma_ack && ctl.rd_wr) rd_exp.push_back(ctl.dev_out);

        nxt_ack  = 1'b0;
        nxt_end  = 1'b0;
        nxt_dout = ctl.dev_out;
        if (ctl.rqst) begin
            ctl_active = 1'b1;
            ctl_idle   = 0;
        end else if (ctl_active) begin
            if (ctl_budget > 0 && ctl.dev_ack && !(ctl_stall && $urandom_range(0, 3) == 0)) begin
                nxt_ack = 1'b1;
                ctl_budget--;
                acks++;
                if (ctl.rd_wr) nxt_dout = DATA_LEN'($urandom);
                if (ctl_budget == 0 && ctl_end_with_last) begin
                    nxt_end    = 1'b1;
                    ctl_active = 1'b0;
                end
            end else if (ctl_budget == 0) begin
                if (ctl_idle >= ctl_gap) begin
                    nxt_end    = 1'b1;
                    ctl_active = 1'b0;
                end
                ctl_idle++;
            end
        end

        @(posedge clk);
        #1;
        cmd_valid    = 1'b0;
        ctl.dma_ack  = nxt_ack;
        ctl.end_flag = nxt_end;
        ctl.dev_out  = nxt_dout;
        s_in_valid   = (wr_src.size() > 0) && !(sin_rand && $urandom_range(0, 2) == 0);
        s_in_data    = (wr_src.size() > 0) ? wr_src[0] : '0;
        if (mout_hold > 0) begin
            m_out_ready = 1'b0;
            mout_hold--;
        end else begin
            m_out_ready = mout_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    endtask

    task automatic run_xfer(input string tag, input bit rd, input logic [ADD_LEN:0] addr,
                            input int len, input int budget, input bit end_last, input int gap,
                            input int hold, input bit rnd, input int abort_acks);
        int cyc;
        wr_exp.delete();
        rd_exp.delete();
        ctl_budget = budget;  ctl_end_with_last = end_last;  ctl_gap = gap;
        ctl_stall  = rnd;     sin_rand = rnd;  mout_rand = rnd;
        ctl_active = 1'b0;    ctl_idle = 0;
        rqst_cnt = 0;  done_cnt = 0;  acks = 0;  delivered = 0;  sin_rdy_cnt = 0;
        mout_hold   = hold;
        m_out_ready = (hold > 0) ? 1'b0 : 1'b1;
        s_in_valid  = (wr_src.size() > 0);
        s_in_data   = (wr_src.size() > 0) ? wr_src[0] : '0;
        cmd_valid = 1'b1;  cmd_rd_wr = rd;  cmd_addr = addr;  cmd_len = ADD_LEN'(len);
        check({tag, "/cmd_ready"}, cmd_ready, 1);
        cycle();
        check({tag, "/req_rqst"},  ctl.rqst, 1);
        check({tag, "/req_busy"},  busy, 1);
        check({tag, "/req_cmd_ready"}, cmd_ready, 0);
        check({tag, "/rd_wr"},      ctl.rd_wr, rd);
        check({tag, "/start_addr"}, ctl.start_addr, addr);
        check({tag, "/num_words"},  ctl.num_words, len);
        cyc = 0;
        while (done_cnt == 0 && cyc < 500) begin
            cycle();
            cyc++;
            if (abort_acks > 0 && acks >= abort_acks) begin
                reset = 1'b0;
                #1;
                check_reset_vals({tag, "/async_reset"});
                ctl.dma_ack = 1'b0;  ctl.end_flag = 1'b0;  s_in_valid = 1'b0;
                wr_src.delete();  wr_exp.delete();  rd_exp.delete();
                ctl_active = 1'b0;
                @(negedge clk);
                check_reset_vals({tag, "/held_reset"});
                reset = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            if (hold > 0 && cyc == 8) begin
                check({tag, "/hold_acks"},     acks, BUF_DEPTH);
                check({tag, "/hold_dev_ack"},  ctl.dev_ack, 0);
                check({tag, "/hold_buffered"}, rd_exp.size(), BUF_DEPTH);
                check({tag, "/hold_delivered"}, delivered, 0);
            end
        end
        check({tag, "/done_seen"}, done_cnt, 1);
        check({tag, "/short"}, short, budget != len);
        check({tag, "/idle_after_done"}, busy, 0);
        cycle();
        cycle();
        check({tag, "/done_pulse"}, done_cnt, 1);
        check({tag, "/rqst_pulse"}, rqst_cnt, 1);
        check({tag, "/acks"}, acks, budget);
        check({tag, "/wr_pending"}, wr_exp.size(), 0);
        check({tag, "/rd_pending"}, rd_exp.size(), 0);
        check({tag, "/delivered"}, delivered, rd ? budget : 0);
        check({tag, "/short_held"}, short, budget != len);
        if (!rd) check({tag, "/src_sent"}, wr_src.size(), 0);
    endtask

    initial begin
        bit               rd;
        int               len;
        logic [ADD_LEN:0] addr;

        reset = 1'b0;  cmd_valid = 1'b0;  cmd_rd_wr = 1'b0;  cmd_addr = '0;  cmd_len = '0;
        s_in_valid = 1'b0;  s_in_data = '0;  m_out_ready = 1'b0;
        ctl.dma_ack = 1'b0;  ctl.end_flag = 1'b0;  ctl.dev_out = '0;
        sin_rand = 1'b0;  mout_rand = 1'b0;  mout_hold = 0;  ctl_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("in_reset");
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("after_reset");

        // Write of three known words.
        wr_src = '{16'h00A1, 16'h00A2, 16'h00A3};
        run_xfer("wr3", 1'b0, 17'h00200, 3, 3, 1'b0, 0, 0, 1'b0, 0);

        // Read of six words with the peripheral stalled at the start.
        run_xfer("rd6_hold", 1'b1, 17'h00400, 6, 6, 1'b0, 0, 10, 1'b0, 0);

        // Odd start address is rejected.
        rqst_cnt = 0;
        cmd_valid = 1'b1;  cmd_rd_wr = 1'b0;  cmd_addr = 17'h00201;  cmd_len = 16'd3;
        cycle();
        check("odd/err_pulse", err, 1);
        check("odd/cmd_ready", cmd_ready, 1);
        check("odd/busy", busy, 0);
        check("odd/start_addr_kept", ctl.start_addr, 17'h00400);
        check("odd/num_words_kept", ctl.num_words, 6);
        cycle();
        check("odd/err_cleared", err, 0);
        cycle();
        check("odd/no_rqst", rqst_cnt, 0);
        check("odd/cmd_ready_after", cmd_ready, 1);

        // Zero-length transfer still requests and completes.
        run_xfer("len0", 1'b0, 17'h00800, 0, 0, 1'b0, 1, 0, 1'b0, 0);
        check("len0/no_s_in_ready", sin_rdy_cnt, 0);

        // Controller ends a four-word read after two words.
        run_xfer("rd_short", 1'b1, 17'h00A00, 4, 2, 1'b0, 0, 0, 1'b0, 0);

        // Randomized transfers with stalls on every side.
        for (int t = 0; t < 6; t++) begin
            rd   = ($urandom_range(0, 1) == 1);
            len  = $urandom_range(1, 12);
            addr = (ADD_LEN+1)'($urandom) & 17'h1FFFE;
            if (!rd) for (int i = 0; i < len; i++) wr_src.push_back(DATA_LEN'($urandom));
            run_xfer($sformatf("rand%0d", t), rd, addr, len, len,
                     ($urandom_range(0, 1) == 1), $urandom_range(0, 2), 0, 1'b1, 0);
        end

        // Reset in the middle of a five-word write, then a fresh command.
        for (int i = 0; i < 5; i++) wr_src.push_back(DATA_LEN'(16'hB000 + i));
        run_xfer("wr_abort", 1'b0, 17'h00C00, 5, 5, 1'b0, 0, 0, 1'b0, 2);
        for (int i = 0; i < 3; i++) wr_src.push_back(DATA_LEN'($urandom));
        run_xfer("wr_after_reset", 1'b0, 17'h00E00, 3, 3, 1'b1, 0, 0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dma_dev_bridge.md
# dma_dev_bridge

- Device-side bridge directly upstream/downstream of the DMA controller.
- Takes one transfer command from a peripheral: start byte address, word count, direction.
  - Issues the request to the DMA controller.
  - Streams words between a ready/valid peripheral port and the controller's dev_ack/dma_ack word handshake.
  - A small local buffer absorbs the controller's one-cycle ack latency.
- Reports completion, odd-address rejection and short transfers.

## Interface
Parameters:
- ADD_LEN, 16, address/count width (start_addr is ADD_LEN+1 bits)
- DATA_LEN, 16, word width
- BUF_DEPTH, 4, local buffer entries, power of two, ≥2

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_rd_wr  in  1  1 = memory→peripheral, 0 = peripheral→memory
- cmd_addr  in  ADD_LEN+1  start byte address
- cmd_len  in  ADD_LEN  word count
- s_in_valid / s_in_ready / s_in_data  in/out/in  1/1/DATA_LEN  peripheral→bridge stream (write direction)
- m_out_valid / m_out_ready / m_out_data  out/in/out  1/1/DATA_LEN  bridge→peripheral stream (read direction)
- rqst, rd_wr  out  1  request pulse and direction to DMA controller
- start_addr  out  ADD_LEN+1; num_words  out  ADD_LEN  latched command fields
- dev_ack  out  1  write: dev_in valid; read: space for a word
- dev_in  out  DATA_LEN  buffer head word
- dma_ack  in  1  word transferred this cycle
- dev_out  in  DATA_LEN  read data, valid when dma_ack
- end_flag  in  1  controller finished
- busy  out  1  not IDLE
- done, err  out  1  one-cycle pulses
- short  out  1  level, words moved ≠ cmd_len; held until next accepted command

## Operation
States: IDLE, REQ, WR_XFER, RD_XFER, DRAIN, DONE.

- **IDLE, cmd_valid=1:**
  - cmd_addr[0]=1: err pulse next cycle, stay IDLE, nothing latched.
  - Otherwise latch cmd_addr, cmd_len, cmd_rd_wr, clear buffer, word counters and short, go to REQ.
- **REQ:** rqst=1 for exactly one cycle, then WR_XFER (rd_wr=0) or RD_XFER (rd_wr=1). start_addr/num_words/rd_wr hold the latched values until IDLE.
- **WR_XFER:**
  - s_in_ready = buffer not full AND in_cnt < len. Accepted words push; in_cnt++.
  - dev_ack = (buf_cnt − dma_ack) ≥ 1. dma_ack pops the head; xfer_cnt++.
  - end_flag → DONE.
- **RD_XFER:**
  - dma_ack pushes dev_out; xfer_cnt++.
  - dev_ack = (BUF_DEPTH − (buf_cnt + dma_ack − pop)) ≥ 1.
  - m_out_valid = buffer not empty; pop on m_out_valid & m_out_ready.
  - end_flag → DRAIN.
- **DRAIN:** dev_ack=0; continue popping to m_out; buffer empty → DONE.
- **DONE:** done=1 for one cycle; short=(xfer_cnt≠len) registered; → IDLE.
- **cmd_len=0:** rqst still issued. end_flag expected with no words; done with short=0.
- **Overflow:** dma_ack with buffer full in RD_XFER, or with buffer empty in WR_XFER, is a protocol violation. Word is dropped; short forced to 1 at DONE.
- **Simultaneous events:**
  - end_flag and dma_ack in the same cycle: word is counted before the state change.
  - Push and pop in the same cycle: buf_cnt unchanged.
- **Reset mid-operation:** all state and the buffer clear immediately; the controller is reset independently.
- **Outputs after reset:** rqst, dev_ack, s_in_ready, m_out_valid, busy, done, err, short = 0; cmd_ready = 1; start_addr, num_words, rd_wr, dev_in, m_out_data = 0.

## Timing
- Command accepted at edge t. REQ at t+1 (rqst high), transfer state at t+2.
- dev_ack is combinational from buf_cnt and dma_ack; no combinational path from dev_ack to dma_ack exists upstream.
- The controller answers dev_ack in cycle n with dma_ack in cycle n+1. The buffer rules above guarantee the word (write) or the slot (read) exists at n+1.
- s_in_data pushed at edge e appears on dev_in from e+1 (buffer latency one cycle).
- dev_out captured with dma_ack at edge e gives m_out_valid from e+1.
- done asserts one cycle after end_flag (write), or one cycle after the buffer empties (read).
- All counters are ADD_LEN wide; no wrap, since len ≤ 2^ADD_LEN−1.

## Structure
- Shared package dma_pkg holds:
  - state encoding for this block;
  - RD_MEM=1 / WR_MEM=0 direction constants;
  - default ADD_LEN/DATA_LEN.
- One sub-module, dma_bridge_fifo: synchronous BUF_DEPTH FIFO with count output and simultaneous push/pop. Used once, its direction selected by state.

## Test plan
- Write, len=3, addr=0x0200:
  - One-cycle rqst, rd_wr=0, num_words=3.
  - Peripheral sends 0xA1, 0xA2, 0xA3; controller model acks each cycle.
  - dev_in shows 0xA1..0xA3 in order; done with short=0.
- Read, len=6, BUF_DEPTH=4, m_out_ready held 0 for 10 cycles:
  - dev_ack drops once 3 words are buffered plus 1 in flight; no overflow.
  - After release, all 6 words exit in order; done after end_flag and drain.
- cmd_addr=0x0201: err pulse, rqst never asserted, cmd_ready stays 1.
- cmd_len=0:
  - rqst issued; model returns end_flag after 2 cycles.
  - done with short=0; no stream traffic.
- Read len=4, model sends end_flag after 2 words: done with short=1; the 2 words delivered.
- Reset asserted mid write, at word 2 of 5:
  - All outputs return to reset values asynchronously; buffer empty.
  - A new command is accepted after reset deasserts.
